// File: rtl/matrix_pkg.sv
// Shared constants, opcodes and FSM state type for the 5x5 matrix sequencer.
package matrix_pkg;

  localparam int DIM       = 5;
  localparam int ELEM_W    = 8;
  localparam int ROW_W     = DIM * ELEM_W;
  localparam int MATRIX_W  = DIM * ROW_W;
  localparam int ROW_IDX_W = 3;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_OPP   = 3'd2;
  localparam logic [2:0] OP_TRANS = 3'd3;
  localparam logic [2:0] OP_SCALE = 3'd4;

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit offset of element (r,c) inside a flattened matrix.
  function automatic int elem_lsb(input int r, input int c);
    return (r * DIM + c) * ELEM_W;
  endfunction

endpackage

// File: rtl/matrix_row_alu.sv
// Combinational row datapath: produces one result row for the selected operation.
module matrix_row_alu
  import matrix_pkg::*;
(
  input  logic [2:0]            opcode,
  input  logic [ROW_IDX_W-1:0]  row,
  input  logic [MATRIX_W-1:0]   matrix_a,
  input  logic [MATRIX_W-1:0]   matrix_b,
  input  logic [ELEM_W-1:0]     scalar,
  output logic [ROW_W-1:0]      row_result,
  output logic                  invalid
);

  int                  r;
  logic [ELEM_W-1:0]   a_rc;
  logic [ELEM_W-1:0]   b_rc;
  logic [ELEM_W-1:0]   a_cr;
  logic [ELEM_W-1:0]   elem;
  logic [2*ELEM_W-1:0] prod;

  // Per-column element operation; low bits of every result give 8-bit wrap-around.
  always_comb begin
    row_result = '0;
    invalid    = (opcode > OP_SCALE);
    a_rc       = '0;
    b_rc       = '0;
    a_cr       = '0;
    elem       = '0;
    prod       = '0;
    // Rows past the matrix never occur in normal sequencing; clamp to keep selects in range.
    r = (int'(row) < DIM) ? int'(row) : 0;
    for (int c = 0; c < DIM; c++) begin
      a_rc = matrix_a[elem_lsb(r, c) +: ELEM_W];
      b_rc = matrix_b[elem_lsb(r, c) +: ELEM_W];
      a_cr = matrix_a[elem_lsb(c, r) +: ELEM_W];
      // Low half of the product is identical for signed and unsigned operands.
      prod = {{ELEM_W{1'b0}}, a_rc} * {{ELEM_W{1'b0}}, scalar};
      case (opcode)
        OP_ADD:   elem = a_rc + b_rc;
        OP_SUB:   elem = a_rc - b_rc;
        OP_OPP:   elem = {ELEM_W{1'b0}} - a_rc;
        OP_TRANS: elem = a_cr;
        OP_SCALE: elem = prod[ELEM_W-1:0];
        default:  elem = '0;
      endcase
      row_result[c*ELEM_W +: ELEM_W] = elem;
    end
  end

endmodule

// File: rtl/matrix_op_controller.sv
// Sequencer for the 5x5 matrix coprocessor: latches a request, computes one
// result row per cycle through a shared row ALU and pulses done when finished.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands latched on acceptance
// EXEC    | writing result row row_cnt, five cycles total
// DONE    | last row written; done pulse and error update follow
module matrix_op_controller
  import matrix_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          opcode,
  input  logic [ELEM_W-1:0]   scalar,
  input  logic [MATRIX_W-1:0] matrix_a,
  input  logic [MATRIX_W-1:0] matrix_b,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [MATRIX_W-1:0] result
);

  state_t                state;
  state_t                state_nxt;
  logic [ROW_IDX_W-1:0]  row_cnt;
  logic [2:0]            op_q;
  logic [ELEM_W-1:0]     scalar_q;
  logic [MATRIX_W-1:0]   a_q;
  logic [MATRIX_W-1:0]   b_q;
  logic [ROW_W-1:0]      alu_row;
  logic                  alu_invalid;

  matrix_row_alu u_row_alu (
    .opcode     (op_q),
    .row        (row_cnt),
    .matrix_a   (a_q),
    .matrix_b   (b_q),
    .scalar     (scalar_q),
    .row_result (alu_row),
    .invalid    (alu_invalid)
  );

  // Busy covers EXEC and DONE; it drops in the same cycle the done pulse appears.
  assign busy = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_EXEC;
      ST_EXEC: if (row_cnt == LAST_ROW) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latches, row counter, result register and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      op_q     <= '0;
      scalar_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= opcode;
            scalar_q <= scalar;
            a_q      <= matrix_a;
            b_q      <= matrix_b;
            row_cnt  <= '0;
            error    <= 1'b0;
          end
        end
        ST_EXEC: begin
          result[int'(row_cnt)*ROW_W +: ROW_W] <= alu_row;
          row_cnt <= row_cnt + 1'b1;
        end
        ST_DONE: begin
          done  <= 1'b1;
          error <= alu_invalid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_op_controller.sv
// Self-checking bench for matrix_op_controller: directed vector table,
// multi-cycle handshake/reset sequences and randomized ops against a model.
module tb_matrix_op_controller;

  localparam int N  = 5;
  localparam int EW = 8;
  localparam int MW = 200;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    opcode;
  logic [7:0]    scalar;
  logic [MW-1:0] matrix_a;
  logic [MW-1:0] matrix_b;
  logic          busy;
  logic          done;
  logic          error;
  logic [MW-1:0] result;

  int checks = 0;
  int errors = 0;

  matrix_op_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .scalar   (scalar),
    .matrix_a (matrix_a),
    .matrix_b (matrix_b),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic chk_mat(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] fill(input logic [7:0] v);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N*N; i++) m[i*EW +: EW] = v;
    return m;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N*N; i++) m[i*EW +: EW] = 8'($urandom);
    return m;
  endfunction

  // Reference: unpack to integer grids, apply the math, keep the low 8 bits.
  function automatic logic [MW-1:0] model(input logic [2:0] op, input logic [7:0] sc,
                                          input logic [MW-1:0] a, input logic [MW-1:0] b,
                                          output logic err);
    int ga[N][N];
    int gb[N][N];
    int v;
    logic [31:0] vb;
    logic [MW-1:0] res;
    res = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ga[r][c] = int'($signed(a[(r*N+c)*EW +: EW]));
        gb[r][c] = int'($signed(b[(r*N+c)*EW +: EW]));
      end
    err = (op > 3'd4);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (op)
          3'd0:    v = ga[r][c] + gb[r][c];
          3'd1:    v = ga[r][c] - gb[r][c];
          3'd2:    v = -ga[r][c];
          3'd3:    v = ga[c][r];
          3'd4:    v = int'($signed(sc)) * ga[r][c];
          default: v = 0;
        endcase
        vb = v;
        res[(r*N+c)*EW +: EW] = vb[7:0];
      end
    return res;
  endfunction

  // Issue one request from IDLE; checks handshake timing, scrambles inputs after acceptance.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] sc,
                        input logic [MW-1:0] a, input logic [MW-1:0] b,
                        output logic [MW-1:0] res, output logic err);
    int k;
    int bc;
    opcode   = op;
    scalar   = sc;
    matrix_a = a;
    matrix_b = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    opcode   = 3'($urandom);
    scalar   = 8'($urandom);
    matrix_a = rand_mat();
    matrix_b = rand_mat();
    k  = 0;
    bc = 0;
    while (!done && k < 20) begin
      if (busy) bc++;
      @(posedge clk); #1;
      k++;
    end
    chk_int({tag, " latency"}, k, 6);
    chk_int({tag, " busy_cycles"}, bc, 6);
    chk_int({tag, " busy_at_done"}, int'(busy), 0);
    res = result;
    err = error;
    @(posedge clk); #1;
    chk_int({tag, " done_width"}, int'(done), 0);
    chk_mat({tag, " result_hold"}, result, res);
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [7:0]    sc;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [MW-1:0] exp_res;
    logic          exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [MW-1:0] got_res;
    logic [MW-1:0] exp_res;
    logic          got_err;
    logic          exp_err;
    logic [MW-1:0] ta;
    logic [MW-1:0] te;
    int            k;
    int            seen;

    // Directed vectors with hand-derived expectations.
    ta = '0;
    te = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ta[(r*N+c)*EW +: EW] = 8'(r*5 + c);
        te[(r*N+c)*EW +: EW] = 8'(c*5 + r);
      end
    vecs[0] = '{3'd0, 8'h00, fill(8'h7F), fill(8'h01), fill(8'h80), 1'b0};
    vecs[1] = '{3'd2, 8'h00, '0, rand_mat(), '0, 1'b0};
    vecs[1].a[0 +: 8]          = 8'h80;
    vecs[1].a[24*8 +: 8]       = 8'h05;
    vecs[1].exp_res[0 +: 8]    = 8'h80;
    vecs[1].exp_res[24*8 +: 8] = 8'hFB;
    vecs[2] = '{3'd3, 8'h00, ta, rand_mat(), te, 1'b0};
    vecs[3] = '{3'd4, 8'hFE, fill(8'h03), rand_mat(), fill(8'hFA), 1'b0};
    vecs[4] = '{3'd6, 8'h11, rand_mat(), rand_mat(), '0, 1'b1};
    vecs[5] = '{3'd0, 8'h00, fill(8'h7F), fill(8'h01), fill(8'h80), 1'b0};
    vecs[6] = '{3'd1, 8'h00, fill(8'h80), fill(8'h01), fill(8'h7F), 1'b0};
    vecs[7] = '{3'd4, 8'hFF, fill(8'h80), rand_mat(), fill(8'h80), 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    opcode   = '0;
    scalar   = '0;
    matrix_a = '0;
    matrix_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_int("reset busy", int'(busy), 0);
    chk_int("reset done", int'(done), 0);
    chk_int("reset error", int'(error), 0);
    chk_mat("reset result", result, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      if (i > 0) chk_int($sformatf("vec%0d error_held", i), int'(error), int'(vecs[i-1].exp_err));
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sc, vecs[i].a, vecs[i].b, got_res, got_err);
      chk_mat($sformatf("vec%0d result", i), got_res, vecs[i].exp_res);
      chk_int($sformatf("vec%0d error", i), int'(got_err), int'(vecs[i].exp_err));
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]    rop;
      logic [7:0]    rsc;
      logic [MW-1:0] ra;
      logic [MW-1:0] rb;
      rop = 3'($urandom_range(0, 7));
      rsc = 8'($urandom);
      ra  = rand_mat();
      rb  = rand_mat();
      exp_res = model(rop, rsc, ra, rb, exp_err);
      run_op($sformatf("rnd%0d", i), rop, rsc, ra, rb, got_res, got_err);
      chk_mat($sformatf("rnd%0d result", i), got_res, exp_res);
      chk_int($sformatf("rnd%0d error", i), int'(got_err), int'(exp_err));
    end

    // start held high through a SUB: no retrigger during EXEC, re-accept right after done.
    opcode   = 3'd1;
    scalar   = 8'h00;
    matrix_a = fill(8'h0A);
    matrix_b = fill(8'h03);
    start    = 1'b1;
    @(posedge clk); #1;
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk_int("held latency", k, 6);
    chk_mat("held result", result, fill(8'h07));
    chk_int("held busy_at_done", int'(busy), 0);
    @(posedge clk); #1;
    chk_int("held reaccept busy", int'(busy), 1);
    chk_int("held reaccept done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    // Now in EXEC writing row 2: reset discards the operation.
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk_int("midreset busy", int'(busy), 0);
    chk_int("midreset done", int'(done), 0);
    chk_int("midreset error", int'(error), 0);
    chk_mat("midreset result", result, '0);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk_int("midreset no_done", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
